// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port, with an optional
// pending-write scoreboard that is built only when REG_ARB_SCOREBOARD_EN is defined.
module reg_write_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        P0_I_VALID,
  input  logic [4:0]  P0_I_A,
  input  logic [31:0] P0_I_AV,
  output logic        P0_O_READY,
  input  logic        P1_I_VALID,
  input  logic [4:0]  P1_I_A,
  input  logic [31:0] P1_I_AV,
  output logic        P1_O_READY,
  output logic [4:0]  REG_IW_O_A,
  output logic [31:0] REG_IW_O_AV,
  input  logic        RSV_I_EN,
  input  logic [4:0]  RSV_I_A,
  input  logic [4:0]  QRY_I_A,
  input  logic [4:0]  QRY_I_B,
  output logic        QRY_O_ABUSY,
  output logic        QRY_O_BBUSY
);

  // ptr_q = 1 gives P1 priority when both requesters are valid.
  logic        ptr_q, ptr_d;
  logic        accept;
  logic [4:0]  acc_a;
  logic [31:0] acc_av;
  logic [4:0]  wr_a_q, wr_a_d;
  logic [31:0] wr_av_q, wr_av_d;

  always_comb begin
    P0_O_READY = 1'b0;
    P1_O_READY = 1'b0;
    if (!RST) begin
      P0_O_READY = P0_I_VALID && (!P1_I_VALID || !ptr_q);
      P1_O_READY = P1_I_VALID && (!P0_I_VALID || ptr_q);
    end
  end

  assign accept = P0_O_READY || P1_O_READY;
  assign acc_a  = P0_O_READY ? P0_I_A  : P1_I_A;
  assign acc_av = P0_O_READY ? P0_I_AV : P1_I_AV;

  always_comb begin
    ptr_d   = ptr_q;
    wr_a_d  = '0;
    wr_av_d = '0;
    if (P0_O_READY) ptr_d = 1'b1;
    if (P1_O_READY) ptr_d = 1'b0;
    // A write to register 0 is accepted but presented as a no-op.
    if (accept && (acc_a != 5'd0)) begin
      wr_a_d  = acc_a;
      wr_av_d = acc_av;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= 1'b0;
      wr_a_q  <= '0;
      wr_av_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_a_q  <= wr_a_d;
      wr_av_q <= wr_av_d;
    end
  end

  // Masking with RST drops a write accepted just before reset asserted.
  assign REG_IW_O_A  = RST ? 5'd0  : wr_a_q;
  assign REG_IW_O_AV = RST ? 32'd0 : wr_av_q;

`ifdef REG_ARB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Reserve is applied after clear so a same-cycle reserve wins.
  always_comb begin
    busy_d = busy_q;
    if (accept)   busy_d[acc_a]   = 1'b0;
    if (RSV_I_EN) busy_d[RSV_I_A] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign QRY_O_ABUSY = busy_q[QRY_I_A];
  assign QRY_O_BBUSY = busy_q[QRY_I_B];
`else
  logic unused_sb;
  assign unused_sb   = ^{RSV_I_EN, RSV_I_A, QRY_I_A, QRY_I_B};
  assign QRY_O_ABUSY = 1'b0;
  assign QRY_O_BBUSY = 1'b0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Table-driven bench for reg_write_arbiter; expected writes are queued per cycle and
// compared one cycle later. Scoreboard expectations follow REG_ARB_SCOREBOARD_EN.
module tb_reg_write_arbiter;

`ifdef REG_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        P0_I_VALID, P1_I_VALID;
  logic [4:0]  P0_I_A, P1_I_A;
  logic [31:0] P0_I_AV, P1_I_AV;
  logic        P0_O_READY, P1_O_READY;
  logic [4:0]  REG_IW_O_A;
  logic [31:0] REG_IW_O_AV;
  logic        RSV_I_EN;
  logic [4:0]  RSV_I_A, QRY_I_A, QRY_I_B;
  logic        QRY_O_ABUSY, QRY_O_BBUSY;

  always #5 CLK = ~CLK;

  reg_write_arbiter dut (
    .CLK(CLK), .RST(RST),
    .P0_I_VALID(P0_I_VALID), .P0_I_A(P0_I_A), .P0_I_AV(P0_I_AV), .P0_O_READY(P0_O_READY),
    .P1_I_VALID(P1_I_VALID), .P1_I_A(P1_I_A), .P1_I_AV(P1_I_AV), .P1_O_READY(P1_O_READY),
    .REG_IW_O_A(REG_IW_O_A), .REG_IW_O_AV(REG_IW_O_AV),
    .RSV_I_EN(RSV_I_EN), .RSV_I_A(RSV_I_A),
    .QRY_I_A(QRY_I_A), .QRY_I_B(QRY_I_B),
    .QRY_O_ABUSY(QRY_O_ABUSY), .QRY_O_BBUSY(QRY_O_BBUSY)
  );

  typedef struct {
    bit          rst;
    bit          v0;
    logic [4:0]  a0;
    logic [31:0] av0;
    bit          v1;
    logic [4:0]  a1;
    logic [31:0] av1;
    bit          ren;
    logic [4:0]  ra;
    logic [4:0]  qa;
    logic [4:0]  qb;
    bit          r0;
    bit          r1;
    bit          ab;
    bit          bb;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] av;
  } wr_t;

  wr_t  exp_q[$];
  vec_t tbl[16];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit rst, bit v0, logic [4:0] a0, logic [31:0] av0,
                              bit v1, logic [4:0] a1, logic [31:0] av1, bit r0, bit r1);
    vec_t v;
    v = '{rst: rst, v0: v0, a0: a0, av0: av0, v1: v1, a1: a1, av1: av1,
          ren: 1'b0, ra: 5'd0, qa: 5'd0, qb: 5'd0, r0: r0, r1: r1, ab: 1'b0, bb: 1'b0};
    return v;
  endfunction

  function automatic vec_t sb(vec_t base, bit ren, logic [4:0] ra, logic [4:0] qa,
                              logic [4:0] qb, bit ab, bit bb);
    vec_t v;
    v     = base;
    v.ren = ren;
    v.ra  = ra;
    v.qa  = qa;
    v.qb  = qb;
    v.ab  = ab;
    v.bb  = bb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check combinational outputs and last cycle's write, queue this cycle's.
  task automatic apply(input vec_t v, input string tag);
    wr_t e, n;
    @(posedge CLK);
    #1;
    RST        = v.rst;
    P0_I_VALID = v.v0; P0_I_A = v.a0; P0_I_AV = v.av0;
    P1_I_VALID = v.v1; P1_I_A = v.a1; P1_I_AV = v.av1;
    RSV_I_EN   = v.ren; RSV_I_A = v.ra;
    QRY_I_A    = v.qa;  QRY_I_B = v.qb;
    #1;
    chk({tag, ".p0_ready"}, {31'd0, P0_O_READY}, {31'd0, v.r0});
    chk({tag, ".p1_ready"}, {31'd0, P1_O_READY}, {31'd0, v.r1});
    chk({tag, ".abusy"}, {31'd0, QRY_O_ABUSY}, {31'd0, v.ab});
    chk({tag, ".bbusy"}, {31'd0, QRY_O_BBUSY}, {31'd0, v.bb});
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.queue: got empty scoreboard, expected one entry", tag);
      e = '{a: 5'd0, av: 32'd0};
    end else begin
      e = exp_q.pop_front();
    end
    if (v.rst) e = '{a: 5'd0, av: 32'd0};
    chk({tag, ".wr_a"}, {27'd0, REG_IW_O_A}, {27'd0, e.a});
    chk({tag, ".wr_av"}, REG_IW_O_AV, e.av);
    n = '{a: 5'd0, av: 32'd0};
    if (!v.rst && v.r0 && v.a0 != 5'd0) n = '{a: v.a0, av: v.av0};
    if (!v.rst && v.r1 && v.a1 != 5'd0) n = '{a: v.a1, av: v.av1};
    exp_q.push_back(n);
  endtask

  initial begin
    RST = 1'b1;
    P0_I_VALID = 1'b0; P0_I_A = '0; P0_I_AV = '0;
    P1_I_VALID = 1'b0; P1_I_A = '0; P1_I_AV = '0;
    RSV_I_EN = 1'b0; RSV_I_A = '0; QRY_I_A = '0; QRY_I_B = '0;

    tbl[0]  = mk(1, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0);
    tbl[1]  = mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tbl[2]  = mk(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 1, 0);
    tbl[3]  = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tbl[4]  = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tbl[5]  = mk(1, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0, 0);
    tbl[6]  = mk(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 0);
    tbl[7]  = mk(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0, 1);
    tbl[8]  = mk(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 0);
    tbl[9]  = mk(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0, 1);
    tbl[10] = mk(0, 0, 5'd0, 32'h0, 1, 5'd17, 32'hCAFE, 0, 1);
    tbl[11] = mk(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 1, 0);
    tbl[12] = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tbl[13] = mk(0, 1, 5'd4, 32'h44, 0, 5'd0, 32'h0, 1, 0);
    tbl[14] = mk(1, 1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, 0);
    tbl[15] = mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);

    exp_q.push_back('{a: 5'd0, av: 32'd0});
    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Scoreboard: reserve, clear by write, reserve-wins collision, register 0, reset.
    apply(sb(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0), 1, 5'd7, 5'd7, 5'd0, 0, 0), "rsv7");
    apply(sb(mk(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 0, 1), 0, 5'd0, 5'd7, 5'd0, SB, 0), "wr7");
    apply(sb(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0), 1, 5'd9, 5'd7, 5'd9, 0, 0), "rsv9");
    apply(sb(mk(0, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 1, 0), 1, 5'd9, 5'd0, 5'd9, 0, SB), "coll9");
    apply(sb(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0), 1, 5'd0, 5'd0, 5'd9, 0, SB), "rsv0");
    apply(sb(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0), 1, 5'd3, 5'd0, 5'd3, 0, 0), "rsv3");
    apply(sb(mk(0, 1, 5'd4, 32'h4, 0, 5'd0, 32'h0, 1, 0), 0, 5'd0, 5'd3, 5'd9, SB, SB), "busy39");
    apply(sb(mk(1, 1, 5'd4, 32'h4, 1, 5'd5, 32'h5, 0, 0), 0, 5'd0, 5'd3, 5'd9, SB, SB), "rstsb");
    apply(sb(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0), 0, 5'd0, 5'd3, 5'd9, 0, 0), "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, expected finish within 100000");
    $fatal(1);
  end

endmodule
